// File: rtl/cfg_lut_cell.sv
// K-input configurable logic cell loaded through a serial configuration chain.
// Define CFG_LUT_PIN_MERGE_EN to add a K-bit pin-merge mask to the chain.
module cfg_lut_cell #(
    parameter int unsigned K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_en,
    input  logic         cfg_din,
    output logic         cfg_dout,
    output logic         cfg_done,
    input  logic [K-1:0] in,
    output logic         out
);

    localparam int unsigned TT_N = 2**K;
`ifdef CFG_LUT_PIN_MERGE_EN
    localparam int unsigned L    = TT_N + 1 + K;
`else
    localparam int unsigned L    = TT_N + 1;
`endif
    localparam int unsigned CW   = $clog2(L + 1);

    logic [L-1:0]    sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            q_q, q_d;

    logic [TT_N-1:0] tt;
    logic [K-1:0]    idx;
    logic            reg_mode;
    logic            active;
    logic            f;

    // Lookup, gating and configuration-chain next state
    always_comb begin
        tt       = sr_q[TT_N-1:0];
        reg_mode = sr_q[TT_N];
        idx      = in;
`ifdef CFG_LUT_PIN_MERGE_EN
        // mask bit 0 has no meaning: in[0] is the merge target itself
        for (int unsigned i = 1; i < K; i++) begin
            if (sr_q[TT_N+1+i]) begin
                idx[i] = in[0];
            end
        end
`endif
        f        = tt[idx];
        cfg_done = (cnt_q == CW'(L));
        active   = cfg_done & ~cfg_en;
        cfg_dout = sr_q[0];

        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (cfg_en) begin
            sr_d = {cfg_din, sr_q[L-1:1]};
            if (!cfg_done) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        q_d = active & f;
        out = reg_mode ? q_q : (active & f);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

endmodule

// File: tb/tb_cfg_lut_cell.sv
// Randomized bench for cfg_lut_cell against a shift-history reference model.
module tb_cfg_lut_cell;

    localparam int K    = 4;
    localparam int TT_N = 2**K;
`ifdef CFG_LUT_PIN_MERGE_EN
    localparam int L    = TT_N + 1 + K;
`else
    localparam int L    = TT_N + 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_en = 1'b0;
    logic         cfg_din = 1'b0;
    logic [K-1:0] in_v = '0;
    logic         cfg_dout;
    logic         cfg_done;
    logic         out_v;

    int n_vec = 0;
    int n_err = 0;

    // Model: every bit shifted since reset, plus the modelled output flop
    bit hist[$];
    bit exp_q;

    cfg_lut_cell #(.K(K)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_en   (cfg_en),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .cfg_done (cfg_done),
        .in       (in_v),
        .out      (out_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Chain position j holds the bit shifted in L-j shifts ago (0 if none yet)
    function automatic bit m_bit(input int j);
        int p;
        p = hist.size() - L + j;
        if (p < 0) return 1'b0;
        return hist[p];
    endfunction

    function automatic bit m_done();
        return hist.size() >= L;
    endfunction

    function automatic bit m_f(input logic [K-1:0] iv);
        int idx;
        bit b;
        idx = 0;
        for (int i = 0; i < K; i++) begin
            b = iv[i];
`ifdef CFG_LUT_PIN_MERGE_EN
            if (i > 0 && m_bit(TT_N + 1 + i)) b = iv[0];
`endif
            if (b) idx += (1 << i);
        end
        return m_bit(idx);
    endfunction

    function automatic bit m_comb(input bit en, input logic [K-1:0] iv);
        return m_done() && !en && m_f(iv);
    endfunction

    task automatic check_outs();
        bit exp_out;
        exp_out = m_bit(TT_N) ? exp_q : m_comb(cfg_en, in_v);
        chk("cfg_done", cfg_done, m_done());
        chk("cfg_dout", cfg_dout, m_bit(0));
        chk("out", out_v, exp_out);
    endtask

    // One clock cycle: drive, check mid-cycle, then advance model with the edge
    task automatic step(input bit en, input bit din, input logic [K-1:0] iv);
        bit nq;
        cfg_en  = en;
        cfg_din = din;
        in_v    = iv;
        @(negedge clk);
        check_outs();
        nq = m_comb(en, iv);
        @(posedge clk);
        if (en) hist.push_back(din);
        exp_q = nq;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_dout", cfg_dout, 1'b0);
        chk("rst_out", out_v, 1'b0);
        hist.delete();
        exp_q   = 1'b0;
        cfg_en  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [K-1:0] v;
        int n;
        exp_q = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed: single-minterm truth table, comb mode, done after exactly L edges
        for (int i = 0; i < L - 1; i++) begin
            step(1'b1, (i == TT_N - 1), K'($urandom));
        end
        chk("done_before_last", cfg_done, 1'b0);
        step(1'b1, 1'b0, '0);
        chk("done_at_L", cfg_done, 1'b1);
        cfg_en = 1'b0;
        for (int i = 0; i < TT_N; i++) begin
            v    = K'(i);
            in_v = v;
            #1;
            chk("minterm_sweep", out_v, (i == TT_N - 1));
        end

        // Directed: reset mid-load, then partial reload keeps done low
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '1);
        do_reset();
        for (int i = 0; i < L - 1; i++) step(1'b1, $urandom_range(0, 1) != 0, K'($urandom));
        chk("partial_reload", cfg_done, 1'b0);
        step(1'b1, 1'b1, '1);
        chk("full_reload", cfg_done, 1'b1);

        // Randomized mix of loads, runs, enable pulses and resets
        repeat (80) begin
            case ($urandom_range(0, 5))
                0, 1: for (int i = 0; i < L; i++)
                          step(1'b1, $urandom_range(0, 1) != 0, K'($urandom));
                2:    repeat (8) step(1'b0, $urandom_range(0, 1) != 0, K'($urandom));
                3: begin
                    step(1'b1, $urandom_range(0, 1) != 0, K'($urandom));
                    repeat (3) step(1'b0, 1'b0, K'($urandom));
                end
                4: begin
                    n = $urandom_range(1, L - 1);
                    for (int i = 0; i < n; i++)
                        step(1'b1, $urandom_range(0, 1) != 0, K'($urandom));
                    do_reset();
                end
                default: repeat (8)
                    step($urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0, K'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
